priority_index_buffer: RTL
==========================

Name: priority_index_buffer

Overview:
- Downstream consumer of the priority encoder. Takes its one-hot left/right outputs and converts each to a binary bit index.
- Adds zero and error qualifiers and, optionally, the span between the two indices.
- Buffers results in a small show-ahead FIFO with a valid/ready output handshake, so a stalling sink does not lose encoder results.
- The upstream encoder has no backpressure. Entries arriving while the FIFO is full are dropped and flagged.

Parameters:
- WIDTH, 16, width of the one-hot input words. Must be ≥2.
- DEPTH, 4, FIFO entries. Must be a power of two, ≥2.
- Derived, not overridable: IDX_W = $clog2(WIDTH); CNT_W = $clog2(DEPTH)+1.

Ports:
- clk_i  in  1  clock, rising edge
- arst_i  in  1  reset, asynchronous, active-high
- data_left_i  in  WIDTH  one-hot MSB-of-word from encoder
- data_right_i  in  WIDTH  one-hot LSB-of-word from encoder
- data_val_i  in  1  input qualifier, single-cycle pulses or continuous
- left_idx_o  out  IDX_W  bit index of head-entry left word
- right_idx_o  out  IDX_W  bit index of head-entry right word
- span_o  out  IDX_W  left_idx − right_idx (see Optional Feature)
- zero_o  out  1  head entry had both inputs all-zero
- err_o  out  1  head entry had an input with more than one bit set
- data_val_o  out  1  head entry valid (FIFO not empty)
- data_ready_i  in  1  sink accepts head entry
- full_o  out  1  FIFO holds DEPTH entries
- empty_o  out  1  FIFO holds 0 entries
- usedw_o  out  CNT_W  entries currently stored
- overflow_o  out  1  sticky: an entry was dropped
- ovf_clr_i  in  1  synchronous clear of overflow_o

Behaviour:
- Reset (arst_i high, asynchronous): all state cleared immediately. All outputs 0, except empty_o=1. Pointers and the count go to 0, the stage register is invalid, and overflow_o=0. Deassertion is synchronous to clk_i in the surrounding logic.
- Stage 1, conversion register: on each edge with data_val_i=1, capture the converted fields and set the stage-valid bit. With data_val_i=0, clear stage-valid.
- Conversion rules:
  - right_idx = index of the lowest set bit of data_right_i.
  - left_idx = index of the highest set bit of data_left_i.
  - All-zero word gives index 0.
  - zero = both words all-zero.
  - err = either word has popcount >1. The index is still computed per the rules above.
  - A word that is zero while the other is non-zero gives zero=0 and err=0.
- Stage 2, FIFO write: occurs on the edge after capture when stage-valid=1.
  - Write is accepted if not full, or if a read occurs on the same edge.
  - Otherwise the entry is dropped and overflow_o is set on that edge.
- Latency: data_val_i sampled at edge k. The entry is written at edge k+1 and visible on the outputs after edge k+1 if the FIFO was empty. There is no empty-to-output bypass.
- Read: the head is popped on an edge where data_val_o=1 and data_ready_i=1. Outputs are show-ahead, i.e. driven combinationally from the head entry.
- Output fields with data_val_o=0: all fields are 0.
- Simultaneous read and write:
  - usedw_o is unchanged.
  - When full, the write succeeds and nothing is dropped.
  - When empty, a read cannot happen, so it reduces to a write only.
- Pointer wrap: modulo DEPTH. full_o and empty_o are derived from the count, never from pointer equality alone.
- ovf_clr_i=1 clears overflow_o on that edge. If a drop occurs on the same edge, set wins and overflow_o stays 1.
- Throughput: one entry per cycle in and out. Sustained data_val_i with data_ready_i=1 never overflows.
- Reset mid-operation: the stage entry and FIFO contents are discarded. No entry is output after reset until new input arrives.

Optional Feature:
- Macro: PRIORITY_INDEX_BUFFER_SPAN_EN.
- Defined: span = left_idx − right_idx, computed in stage 1 in IDX_W bits and stored per entry. span_o is valid with data_val_o.
  - The value is only meaningful when zero=0 and err=0; otherwise it is the modular IDX_W-bit result.
  - For a normal encoder word, left ≥ right, so there is no wrap.
- Undefined: span is not stored, FIFO entry width shrinks by IDX_W, and span_o is tied to 0.

Test Plan (WIDTH=16, DEPTH=4):
- Single pulse, data_left_i=16'h0400, data_right_i=16'h0004, data_ready_i=1:
  - data_val_o=1 exactly one cycle, two edges after the input edge.
  - left_idx_o=10, right_idx_o=2, span_o=8 (macro on) or 0 (macro off), zero_o=0, err_o=0.
- Zero and error handling:
  - Both inputs 0 with valid → zero_o=1, indices 0.
  - data_right_i=16'h0006 → err_o=1, right_idx_o=1.
  - data_left_i=16'h8000 → left_idx_o=15.
- Backpressure/overflow: data_ready_i=0, six consecutive valid inputs with right one-hots 1,2,4,8,16,32.
  - full_o=1, usedw_o=4, overflow_o=1.
  - Releasing ready pops right_idx 0,1,2,3 in order, then empty_o=1.
- Full with simultaneous read and write: FIFO full, data_ready_i=1, continuous input.
  - No drop: overflow_o stays 0, usedw_o stays 4, output order is preserved.
- Clear versus set: ovf_clr_i=1 alone clears overflow_o. ovf_clr_i=1 on the same edge as a drop keeps overflow_o=1.
- Async reset with 3 entries stored and stage valid:
  - Pulse arst_i between edges → all outputs 0 and empty_o=1 immediately, with no clock edge needed.
  - No stale entry appears afterwards.

Source files
------------

// File: rtl/priority_index_buffer.sv
// Converts one-hot left/right encoder words to bit indices with zero/err qualifiers, buffered in a show-ahead FIFO.
// Latency: input sampled at edge k is written at edge k+1 and shows on the outputs after k+1 (no empty bypass).
// Backpressure: valid/ready on the output side only; stage entries that find the FIFO full are dropped and flagged in overflow_o.
// Optional: define PRIORITY_INDEX_BUFFER_SPAN_EN to store span = left_idx - right_idx per entry (else span_o = 0).
module priority_index_buffer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int IDX_W = $clog2(WIDTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic [WIDTH-1:0] data_left_i,
    input  logic [WIDTH-1:0] data_right_i,
    input  logic             data_val_i,
    output logic [IDX_W-1:0] left_idx_o,
    output logic [IDX_W-1:0] right_idx_o,
    output logic [IDX_W-1:0] span_o,
    output logic             zero_o,
    output logic             err_o,
    output logic             data_val_o,
    input  logic             data_ready_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] usedw_o,
    output logic             overflow_o,
    input  logic             ovf_clr_i
);

    localparam int PTR_W = $clog2(DEPTH);

    // Conversion results for the current input words
    logic [IDX_W-1:0] w_left_idx;
    logic [IDX_W-1:0] w_right_idx;
    logic             w_left_seen;
    logic             w_left_multi;
    logic             w_right_seen;
    logic             w_right_multi;
    logic             w_zero;
    logic             w_err;

    // Stage register
    logic             r_stg_vld;
    logic [IDX_W-1:0] r_stg_left;
    logic [IDX_W-1:0] r_stg_right;
    logic             r_stg_zero;
    logic             r_stg_err;

    // FIFO storage and control
    logic [IDX_W-1:0] r_mem_left  [DEPTH];
    logic [IDX_W-1:0] r_mem_right [DEPTH];
    logic             r_mem_zero  [DEPTH];
    logic             r_mem_err   [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;

    logic             w_full;
    logic             w_empty;
    logic             w_rd;
    logic             w_wr;
    logic             w_drop;

`ifdef PRIORITY_INDEX_BUFFER_SPAN_EN
    logic [IDX_W-1:0] w_span;
    logic [IDX_W-1:0] r_stg_span;
    logic [IDX_W-1:0] r_mem_span [DEPTH];

    // Span wraps modulo 2^IDX_W; only meaningful for clean (non-zero, non-err) words
    assign w_span = w_left_idx - w_right_idx;
`endif

    // Highest set bit of left, lowest set bit of right, and multi-hot detection
    always_comb begin
        w_left_idx    = '0;
        w_right_idx   = '0;
        w_left_seen   = 1'b0;
        w_left_multi  = 1'b0;
        w_right_seen  = 1'b0;
        w_right_multi = 1'b0;
        // Ascending scan: the last hit is the highest set bit
        for (int i = 0; i < WIDTH; i++) begin
            if (data_left_i[i]) begin
                w_left_idx = IDX_W'(i);
                if (w_left_seen) w_left_multi = 1'b1;
                w_left_seen = 1'b1;
            end
        end
        // Descending scan: the last hit is the lowest set bit
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (data_right_i[i]) begin
                w_right_idx = IDX_W'(i);
                if (w_right_seen) w_right_multi = 1'b1;
                w_right_seen = 1'b1;
            end
        end
        w_zero = ~w_left_seen & ~w_right_seen;
        w_err  = w_left_multi | w_right_multi;
    end

    // Stage 1: capture converted fields whenever the input is valid
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_stg_vld   <= 1'b0;
            r_stg_left  <= '0;
            r_stg_right <= '0;
            r_stg_zero  <= 1'b0;
            r_stg_err   <= 1'b0;
`ifdef PRIORITY_INDEX_BUFFER_SPAN_EN
            r_stg_span  <= '0;
`endif
        end else begin
            r_stg_vld <= data_val_i;
            if (data_val_i) begin
                r_stg_left  <= w_left_idx;
                r_stg_right <= w_right_idx;
                r_stg_zero  <= w_zero;
                r_stg_err   <= w_err;
`ifdef PRIORITY_INDEX_BUFFER_SPAN_EN
                r_stg_span  <= w_span;
`endif
            end
        end
    end

    // Occupancy flags come from the count so a wrapped pointer pair is never ambiguous
    assign w_full  = (r_cnt == CNT_W'(DEPTH));
    assign w_empty = (r_cnt == '0);
    assign w_rd    = ~w_empty & data_ready_i;
    assign w_wr    = r_stg_vld & (~w_full | w_rd);
    assign w_drop  = r_stg_vld & ~w_wr;

    // Stage 2: FIFO storage write
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_left[i]  <= '0;
                r_mem_right[i] <= '0;
                r_mem_zero[i]  <= 1'b0;
                r_mem_err[i]   <= 1'b0;
`ifdef PRIORITY_INDEX_BUFFER_SPAN_EN
                r_mem_span[i]  <= '0;
`endif
            end
        end else if (w_wr) begin
            r_mem_left[r_wr_ptr]  <= r_stg_left;
            r_mem_right[r_wr_ptr] <= r_stg_right;
            r_mem_zero[r_wr_ptr]  <= r_stg_zero;
            r_mem_err[r_wr_ptr]   <= r_stg_err;
`ifdef PRIORITY_INDEX_BUFFER_SPAN_EN
            r_mem_span[r_wr_ptr]  <= r_stg_span;
`endif
        end
    end

    // Pointers wrap naturally modulo DEPTH; count tracks net push/pop
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_wr, w_rd})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Sticky overflow; a drop on the same edge as a clear keeps it set
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr_i) begin
            r_ovf <= 1'b0;
        end
    end

    // Show-ahead outputs, forced to zero while the FIFO is empty
    assign data_val_o  = ~w_empty;
    assign left_idx_o  = w_empty ? '0   : r_mem_left[r_rd_ptr];
    assign right_idx_o = w_empty ? '0   : r_mem_right[r_rd_ptr];
    assign zero_o      = w_empty ? 1'b0 : r_mem_zero[r_rd_ptr];
    assign err_o       = w_empty ? 1'b0 : r_mem_err[r_rd_ptr];
`ifdef PRIORITY_INDEX_BUFFER_SPAN_EN
    assign span_o      = w_empty ? '0   : r_mem_span[r_rd_ptr];
`else
    assign span_o      = '0;
`endif
    assign full_o      = w_full;
    assign empty_o     = w_empty;
    assign usedw_o     = r_cnt;
    assign overflow_o  = r_ovf;

endmodule
